// File: rtl/pri_enc_32to5.sv
// Sequential 32-to-5 request encoder: sticky pending vector, one index offered
// per cycle on a valid/ready port, fixed (lowest first) or rotating priority.
module pri_enc_32to5 #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned AW          = 5,
    parameter bit          ROUND_ROBIN = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW-1:0]    out_idx,
    output logic [WIDTH-1:0] pending,
    output logic             collide
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    out_idx_q, out_idx_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             collide_q, collide_d;

    logic             accept;
    logic [WIDTH-1:0] grant;
    logic [WIDTH-1:0] nxt;

    function automatic logic [AW-1:0] lowest_idx(input logic [WIDTH-1:0] v);
        logic [AW-1:0] idx;
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) idx = AW'(i);
        end
        return idx;
    endfunction

    // Rotating mode: rotate so ptr lands at bit 0, pick lowest, then un-rotate.
    function automatic logic [AW-1:0] select_idx(input logic [WIDTH-1:0] v,
                                                 input logic [AW-1:0]    ptr);
        logic [WIDTH-1:0] rot;
        logic [AW-1:0]    sel;
        rot = WIDTH'({v, v} >> ptr);
        if (ROUND_ROBIN) sel = AW'(lowest_idx(rot) + ptr);
        else             sel = lowest_idx(v);
        return sel;
    endfunction

    always_comb begin
        state_d   = state_q;
        out_idx_d = out_idx_q;
        ptr_d     = ptr_q;

        accept    = (state_q == OFFER) && out_ready && !clr;
        grant     = accept ? (WIDTH'(1) << out_idx_q) : '0;
        nxt       = (pending_q & ~grant) | req;
        pending_d = nxt;
        collide_d = |(req & pending_q & ~grant);

        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    out_idx_d = select_idx(pending_q, ptr_q);
                    state_d   = OFFER;
                end
            end
            OFFER: begin
                if (accept) begin
                    ptr_d = AW'(out_idx_q + AW'(1));
                    if (|nxt) out_idx_d = select_idx(nxt, ptr_d);
                    else      state_d   = IDLE;
                end
            end
        endcase

        if (clr) begin
            pending_d = '0;
            collide_d = 1'b0;
            state_d   = IDLE;
            out_idx_d = out_idx_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            out_idx_q <= '0;
            ptr_q     <= '0;
            pending_q <= '0;
            collide_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_idx_q <= out_idx_d;
            ptr_q     <= ptr_d;
            pending_q <= pending_d;
            collide_q <= collide_d;
        end
    end

    assign out_valid = (state_q == OFFER);
    assign out_idx   = out_idx_q;
    assign pending   = pending_q;
    assign collide   = collide_q;

endmodule
